fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end feeding the core's IR and PC.
- Generates sequential word-aligned fetch addresses to an instruction memory with variable latency and in-order responses.
- Buffers returned instructions in a DEPTH-entry queue with their PCs and presents them to decode by valid/ready handshake.
- Handles PC redirects from branch resolution by flushing the queue and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, prefetch queue entries (power of two, 2..16); also the cap on outstanding plus buffered instructions.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address, bits [1:0] always 0
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  response data valid (in request order)
- imem_rsp_data  input  32  instruction word
- inst_valid  output  1  queue head valid
- inst_pc  output  32  PC of head instruction
- inst_data  output  32  head instruction word
- inst_ready  input  1  decode consumes head
- redirect_valid  input  1  branch/jump taken, flush
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 0

Behaviour:
- Reset (clk edge with rst=1):
  - fpc = RESET_PC and rpc = RESET_PC.
  - Queue empty, outstanding = 0, drop_cnt = 0.
  - imem_req_valid = 0, inst_valid = 0.
  - inst_pc and inst_data = 0 while empty.
  - Reset mid-transaction abandons everything; responses that arrive after reset are not dropped. The memory must be reset together with this block.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + count < DEPTH). imem_req_addr = fpc.
- Request accept (valid & ready): fpc += 4, wrapping modulo 2^32; outstanding += 1.
- Response (imem_rsp_valid): outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise push {rpc, data} to the queue; rpc += 4.
- Dequeue on inst_valid & inst_ready. Latency: a response is visible at inst_valid on the next cycle (registered queue); there is no combinational response-to-output path.
- Simultaneous push and pop: count is unchanged, including when the queue is full. The credit rule guarantees a push never overflows.
- Redirect (redirect_valid=1), highest priority:
  - Queue cleared; any dequeue this cycle is ignored.
  - fpc and rpc = {redirect_pc[31:2], 2'b00}.
  - No request is issued this cycle.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counters are sized clog2(DEPTH)+1 bits and never over- or underflow under legal stimulus.
- Memory protocol violation (a response when outstanding = 0) is ignored.
- inst_pc and inst_data are stable while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds two 32-bit outputs.
  - perf_fetched: counts dequeues.
  - perf_dropped: counts responses discarded because of a redirect, plus valid entries flushed from the queue.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory ready and one-cycle latency, inst_ready=1 → addresses 0x0, 0x4, 0x8 issued on consecutive cycles; inst_pc 0x0/0x4/0x8 with matching data; one instruction per cycle sustained.
- inst_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0. Raising inst_ready resumes fetch at 0x10 with no loss or duplication.
- Memory latency 3 cycles, redirect to 0x103 while 2 requests are outstanding → queue empties next cycle; the 2 stale responses are discarded; first delivered inst_pc = 0x100.
- Response and redirect in the same cycle with outstanding = 1 → drop_cnt = 0; the response is discarded; the next delivered instruction is the one fetched from the redirect target.
- fpc = 0xFFFF_FFFC → the next request address wraps to 0x0; inst_pc sequence is 0xFFFF_FFFC then 0x0.
- FETCH_PERF_EN defined, 10 instructions consumed, then a redirect with 2 queued and 1 outstanding → perf_fetched = 10, perf_dropped = 3.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential word fetch, DEPTH-entry prefetch queue, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_next;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // valid never depends on ready. Responses need no ready and arrive in request order.
  // Outstanding requests plus buffered entries never exceed DEPTH, so a push always fits.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a memory protocol violation and is ignored.
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_fire && (drop_cnt == '0) && !redirect_valid;

  assign inst_valid = (count != '0);
  assign inst_pc    = inst_valid ? pc_q[head]   : 32'h0;
  assign inst_data  = inst_valid ? data_q[head] : 32'h0;
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path and must be discarded.
        fpc      <= {redirect_pc[31:2], 2'b00};
        rpc      <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= outstanding_next;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) begin
          fpc <= fpc + 32'd4;
        end
        if (rsp_fire && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (rsp_keep) begin
          rpc  <= rpc + 32'd4;
          tail <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      pc_q[tail]   <= rpc;
      data_q[tail] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] drop_inc;

  // Flushed queue entries plus any response discarded this cycle.
  assign drop_inc = (redirect_valid ? 32'(count) : 32'h0)
                  + 32'(rsp_fire && (redirect_valid || (drop_cnt != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_dropped <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + drop_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: vector table for fill/stall/resume plus
// hand-written redirect, wrap and (with FETCH_PERF_EN) counter sequences.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_prefetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_del = 0;
  logic        mem_ready = 1'b1;
  vec_t        vecs[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0} ^ a ^ 32'h1357_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive the memory response, sample, scoreboard any dequeue, advance.
  task automatic step();
    logic        rf;
    logic        sf;
    logic [31:0] ra;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = mem_ready;
    #1;
    rf = imem_req_valid && imem_req_ready;
    ra = imem_req_addr;
    sf = imem_rsp_valid;
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery", inst_pc);
      end else begin
        check32("sb_pc", inst_pc, exp_q[0]);
        check32("sb_data", inst_data, mem_word(exp_q[0]));
        void'(exp_q.pop_front());
      end
      n_del++;
    end
    @(posedge clk);
    cyc++;
    if (sf) void'(mem_q.pop_front());
    if (rf) mem_q.push_back('{addr: ra, due: cyc + lat - 1});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    mem_ready      = 1'b1;
    mem_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check32("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    check32("rst_inst_data", inst_data, 32'h0);
`ifdef FETCH_PERF_EN
    check32("rst_perf_fetched", perf_fetched, 32'h0);
    check32("rst_perf_dropped", perf_dropped, 32'h0);
`endif
    rst   = 1'b0;
    cyc   = 0;
    n_del = 0;
    load_exp(32'h0);
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int guard;
    guard = 0;
    while (n_del < target && guard < budget) begin
      step();
      guard++;
    end
    if (n_del < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d deliveries expected %0d", name, n_del, target);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check32("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    load_exp({pc[31:2], 2'b00});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequences ----------------
  initial begin
    // rdy, req_valid, req_addr, inst_valid, inst_pc (latency 1, memory always ready)
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[11] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[12] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    // Fill to DEPTH with decode stalled, then resume.
    do_reset();
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      inst_ready = vecs[i].rdy;
      #1;
      check32($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].rv});
      if (vecs[i].rv) check32($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].ra);
      check32($sformatf("vec%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].iv});
      check32($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].pc);
      check32($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].iv ? mem_word(vecs[i].pc) : 32'h0);
      step();
    end

    // Latency 3, redirect with two requests outstanding.
    do_reset();
    lat        = 3;
    inst_ready = 1'b1;
    step();
    step();
    redirect_to(32'h0000_0103);
    n_del = 0;
    #1;
    check32("lat3_flush_valid", {31'b0, inst_valid}, 32'h0);
    run_until(2, 40, "lat3");

    // Response and redirect in the same cycle with one outstanding.
    do_reset();
    lat        = 2;
    inst_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    redirect_to(32'h0000_0200);
    mem_ready = 1'b1;
    n_del     = 0;
    #1;
    check32("samecyc_no_push", {31'b0, inst_valid}, 32'h0);
    run_until(2, 30, "samecyc");

    // Fetch PC wraps from the top of the address space.
    do_reset();
    lat        = 1;
    inst_ready = 1'b1;
    redirect_to(32'hFFFF_FFFE);
    n_del = 0;
    #1;
    check32("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    step();
    check32("wrap_addr1", imem_req_addr, 32'h0000_0000);
    run_until(3, 20, "wrap");

    // Full queue flushed by redirect, then back-to-back redirects.
    do_reset();
    lat        = 1;
    inst_ready = 1'b0;
    repeat (8) step();
    check32("full_head_pc", inst_pc, 32'h0);
    check32("full_no_req", {31'b0, imem_req_valid}, 32'h0);
    redirect_to(32'h0000_0040);
    check32("full_flush_valid", {31'b0, inst_valid}, 32'h0);
    check32("full_flush_pc", inst_pc, 32'h0);
    redirect_to(32'h0000_0080);
    redirect_to(32'h0000_0090);
    inst_ready = 1'b1;
    n_del      = 0;
    run_until(3, 30, "b2b");

`ifdef FETCH_PERF_EN
    // Ten consumed, then redirect with two queued and one response arriving.
    do_reset();
    lat        = 1;
    inst_ready = 1'b1;
    run_until(10, 40, "perf");
    inst_ready = 1'b0;
    step();
    redirect_to(32'h0000_0300);
    check32("perf_fetched", perf_fetched, 32'd10);
    check32("perf_dropped", perf_dropped, 32'd3);
    inst_ready = 1'b1;
    n_del      = 0;
    run_until(2, 20, "perf_after");
    check32("perf_dropped_hold", perf_dropped, 32'd3);
`endif

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
